// File: rtl/fde_pkg.sv
// Shared encodings for the fetch/decode/execute slice: ALU ops, forward selects,
// instruction field positions and the PC-aliased register index.
package fde_pkg;
  localparam int PC_REG = 15;

  localparam int OP_HI  = 23;
  localparam int OP_LO  = 20;
  localparam int RD_HI  = 19;
  localparam int RD_LO  = 16;
  localparam int RS1_HI = 15;
  localparam int RS1_LO = 12;
  localparam int RS2_HI = 11;
  localparam int RS2_LO = 8;
  localparam int IMM_HI = 11;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_LSL   = 3'b101,
    ALU_PASSA = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_WB   = 2'b01,
    FWD_M    = 2'b10,
    FWD_REG2 = 2'b11
  } fwd_sel_e;
endpackage

// File: rtl/fde_alu.sv
// Execute stage: operand forwarding muxes, ALU and NZVC flags; purely combinational.
module fde_alu
  import fde_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] fwd_m,
  input  logic [WIDTH-1:0] fwd_wb,
  input  logic [2:0]       alu_ctrl,
  input  logic             src2_imm,
  input  logic [1:0]       fwd1_sel,
  input  logic [1:0]       fwd2_sel,
  output logic [WIDTH-1:0] store_data,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             c
);
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0]   sum, diff;

  always_comb begin
    case (fwd1_sel)
      FWD_WB:  a = fwd_wb;
      FWD_M:   a = fwd_m;
      default: a = rs1_data;
    endcase
    case (fwd2_sel)
      FWD_WB:  store_data = fwd_wb;
      FWD_M:   store_data = fwd_m;
      default: store_data = rs2_data;
    endcase
  end

  assign b    = src2_imm ? imm : store_data;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (alu_ctrl)
      ALU_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        // carry means "no borrow", i.e. A >= B unsigned
        result = diff[WIDTH-1:0];
        c      = ~diff[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_LSL:   result = a << b[4:0];
      ALU_PASSA: result = a;
      default:   result = b;
    endcase
  end

  assign n = result[WIDTH-1];
  assign z = (result == '0);
endmodule

// File: rtl/fde_fetch.sv
// PC register; a branch loads the execute-stage ALU result, a stall holds.
module fde_fetch
  import fde_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fetch_en,
  input  logic             take_branch,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus1
);
  assign pc_plus1 = pc + WIDTH'(1);

  always_ff @(posedge clock) begin
    if (reset)         pc <= '0;
    else if (fetch_en) pc <= take_branch ? branch_target : pc_plus1;
  end
endmodule

// File: rtl/fde_regfile.sv
// 16-entry register file with write-through reads and r15 aliased to pc+1,
// plus decode of the instruction fields.
module fde_regfile
  import fde_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int REGNUM           = 16,
  parameter int ADDRESSWIDTH     = 4,
  parameter int OPCODEWIDTH      = 4,
  parameter int INSTRUCTIONWIDTH = 24
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [INSTRUCTIONWIDTH-1:0] instruction,
  input  logic                        wb_we,
  input  logic [ADDRESSWIDTH-1:0]     wb_addr,
  input  logic [WIDTH-1:0]            wb_data,
  input  logic [WIDTH-1:0]            pc_plus1,
  output logic [WIDTH-1:0]            rs1_data,
  output logic [WIDTH-1:0]            rs2_data,
  output logic [WIDTH-1:0]            imm,
  output logic [ADDRESSWIDTH-1:0]     rd_addr,
  output logic [ADDRESSWIDTH-1:0]     rs1_addr,
  output logic [ADDRESSWIDTH-1:0]     rs2_addr,
  output logic [OPCODEWIDTH-1:0]      opcode
);
  localparam logic [ADDRESSWIDTH-1:0] PC_ADDR = ADDRESSWIDTH'(PC_REG);

  logic [WIDTH-1:0] regs [REGNUM];
  logic             wr_ok;

  assign opcode   = instruction[OP_HI:OP_LO];
  assign rd_addr  = instruction[RD_HI:RD_LO];
  assign rs1_addr = instruction[RS1_HI:RS1_LO];
  assign rs2_addr = instruction[RS2_HI:RS2_LO];
  assign imm      = {{(WIDTH-IMM_HI-1){instruction[IMM_HI]}}, instruction[IMM_HI:0]};

  assign wr_ok = wb_we && (wb_addr != PC_ADDR);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REGNUM; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // r15 is never stored; it always reads as the next fetch address
  assign rs1_data = (rs1_addr == PC_ADDR)               ? pc_plus1 :
                    (wr_ok && wb_addr == rs1_addr)      ? wb_data  : regs[rs1_addr];
  assign rs2_data = (rs2_addr == PC_ADDR)               ? pc_plus1 :
                    (wr_ok && wb_addr == rs2_addr)      ? wb_data  : regs[rs2_addr];
endmodule

// File: rtl/fde_datapath.sv
// Fetch/decode/execute datapath slice; the ALU result doubles as branch target.
module fde_datapath
  import fde_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int REGNUM           = 16,
  parameter int ADDRESSWIDTH     = 4,
  parameter int OPCODEWIDTH      = 4,
  parameter int INSTRUCTIONWIDTH = 24
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        fetch_en,
  input  logic                        take_branch,
  output logic [WIDTH-1:0]            pc,
  output logic [WIDTH-1:0]            pc_plus1,
  input  logic [INSTRUCTIONWIDTH-1:0] instruction_d,
  input  logic                        wb_we,
  input  logic [ADDRESSWIDTH-1:0]     wb_addr,
  input  logic [WIDTH-1:0]            wb_data,
  output logic [WIDTH-1:0]            rs1_data_d,
  output logic [WIDTH-1:0]            rs2_data_d,
  output logic [WIDTH-1:0]            imm_d,
  output logic [ADDRESSWIDTH-1:0]     rd_addr_d,
  output logic [ADDRESSWIDTH-1:0]     rs1_addr_d,
  output logic [ADDRESSWIDTH-1:0]     rs2_addr_d,
  output logic [OPCODEWIDTH-1:0]      opcode_d,
  input  logic [WIDTH-1:0]            rs1_data_e,
  input  logic [WIDTH-1:0]            rs2_data_e,
  input  logic [WIDTH-1:0]            imm_e,
  input  logic [WIDTH-1:0]            fwd_m,
  input  logic [WIDTH-1:0]            fwd_wb,
  input  logic [2:0]                  alu_ctrl_e,
  input  logic                        src2_imm_e,
  input  logic [1:0]                  fwd1_sel_e,
  input  logic [1:0]                  fwd2_sel_e,
  output logic [WIDTH-1:0]            store_data_e,
  output logic [WIDTH-1:0]            alu_result_e,
  output logic                        n_e,
  output logic                        z_e,
  output logic                        v_e,
  output logic                        c_e
);
  fde_fetch #(.WIDTH(WIDTH)) u_fetch (
    .clock(clock), .reset(reset), .fetch_en(fetch_en), .take_branch(take_branch),
    .branch_target(alu_result_e), .pc(pc), .pc_plus1(pc_plus1)
  );

  fde_regfile #(
    .WIDTH(WIDTH), .REGNUM(REGNUM), .ADDRESSWIDTH(ADDRESSWIDTH),
    .OPCODEWIDTH(OPCODEWIDTH), .INSTRUCTIONWIDTH(INSTRUCTIONWIDTH)
  ) u_regfile (
    .clock(clock), .reset(reset), .instruction(instruction_d),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .pc_plus1(pc_plus1),
    .rs1_data(rs1_data_d), .rs2_data(rs2_data_d), .imm(imm_d),
    .rd_addr(rd_addr_d), .rs1_addr(rs1_addr_d), .rs2_addr(rs2_addr_d), .opcode(opcode_d)
  );

  fde_alu #(.WIDTH(WIDTH)) u_alu (
    .rs1_data(rs1_data_e), .rs2_data(rs2_data_e), .imm(imm_e),
    .fwd_m(fwd_m), .fwd_wb(fwd_wb), .alu_ctrl(alu_ctrl_e), .src2_imm(src2_imm_e),
    .fwd1_sel(fwd1_sel_e), .fwd2_sel(fwd2_sel_e), .store_data(store_data_e),
    .result(alu_result_e), .n(n_e), .z(z_e), .v(v_e), .c(c_e)
  );
endmodule

// File: tb/tb_fde_datapath.sv
// Scoreboarded bench: stimulus pushes model predictions, a negedge monitor compares.
module tb_fde_datapath;
  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_en, take_branch;
  logic [31:0] pc, pc_plus1;
  logic [23:0] instruction_d;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] rs1_data_d, rs2_data_d, imm_d;
  logic [3:0]  rd_addr_d, rs1_addr_d, rs2_addr_d, opcode_d;
  logic [31:0] rs1_data_e, rs2_data_e, imm_e, fwd_m, fwd_wb;
  logic [2:0]  alu_ctrl_e;
  logic        src2_imm_e;
  logic [1:0]  fwd1_sel_e, fwd2_sel_e;
  logic [31:0] store_data_e, alu_result_e;
  logic        n_e, z_e, v_e, c_e;

  always #5 clock = ~clock;

  fde_datapath dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en), .take_branch(take_branch),
    .pc(pc), .pc_plus1(pc_plus1), .instruction_d(instruction_d),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs1_data_d(rs1_data_d), .rs2_data_d(rs2_data_d), .imm_d(imm_d),
    .rd_addr_d(rd_addr_d), .rs1_addr_d(rs1_addr_d), .rs2_addr_d(rs2_addr_d),
    .opcode_d(opcode_d), .rs1_data_e(rs1_data_e), .rs2_data_e(rs2_data_e),
    .imm_e(imm_e), .fwd_m(fwd_m), .fwd_wb(fwd_wb), .alu_ctrl_e(alu_ctrl_e),
    .src2_imm_e(src2_imm_e), .fwd1_sel_e(fwd1_sel_e), .fwd2_sel_e(fwd2_sel_e),
    .store_data_e(store_data_e), .alu_result_e(alu_result_e),
    .n_e(n_e), .z_e(z_e), .v_e(v_e), .c_e(c_e)
  );

  typedef struct {
    logic [31:0] pc, pc1, rs1d, rs2d, imm, res, sd;
    logic [3:0]  op, rd, rs1a, rs2a;
    logic        n, z, v, c;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks = 0, failures = 0;
  logic [31:0] m_pc;
  logic [31:0] m_regs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_plus1", pc_plus1, e.pc1);
      chk("opcode_d", 32'(opcode_d), 32'(e.op));
      chk("rd_addr_d", 32'(rd_addr_d), 32'(e.rd));
      chk("rs1_addr_d", 32'(rs1_addr_d), 32'(e.rs1a));
      chk("rs2_addr_d", 32'(rs2_addr_d), 32'(e.rs2a));
      chk("rs1_data_d", rs1_data_d, e.rs1d);
      chk("rs2_data_d", rs2_data_d, e.rs2d);
      chk("imm_d", imm_d, e.imm);
      chk("store_data_e", store_data_e, e.sd);
      chk("alu_result_e", alu_result_e, e.res);
      chk("n_e", 32'(n_e), 32'(e.n));
      chk("z_e", 32'(z_e), 32'(e.z));
      chk("v_e", 32'(v_e), 32'(e.v));
      chk("c_e", 32'(c_e), 32'(e.c));
    end
  end

  // Reference: register read as seen by decode this cycle
  function automatic logic [31:0] ref_read(input logic [3:0] a);
    if (a == 4'd15) return m_pc + 32'd1;
    if (wb_we && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] r);
    if (sel == 2'd1) return fwd_wb;
    if (sel == 2'd2) return fwd_m;
    return r;
  endfunction

  function automatic void ref_exec(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, output logic [31:0] r,
                                   output logic c, output logic v);
    longint sr;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        r  = a + b;
        c  = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        sr = longint'($signed(a)) + longint'($signed(b));
        v  = sr != longint'($signed(r));
      end
      3'd1: begin
        r  = a - b;
        c  = a >= b;
        sr = longint'($signed(a)) - longint'($signed(b));
        v  = sr != longint'($signed(r));
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a;
      default: r = b;
    endcase
  endfunction

  task automatic step();
    exp_t        x;
    logic [31:0] a, b;
    x.pc   = m_pc;
    x.pc1  = m_pc + 32'd1;
    x.op   = instruction_d[23:20];
    x.rd   = instruction_d[19:16];
    x.rs1a = instruction_d[15:12];
    x.rs2a = instruction_d[11:8];
    x.imm  = 32'($signed(instruction_d[11:0]));
    x.rs1d = ref_read(instruction_d[15:12]);
    x.rs2d = ref_read(instruction_d[11:8]);
    a      = ref_fwd(fwd1_sel_e, rs1_data_e);
    x.sd   = ref_fwd(fwd2_sel_e, rs2_data_e);
    b      = src2_imm_e ? imm_e : x.sd;
    ref_exec(a, b, alu_ctrl_e, x.res, x.c, x.v);
    x.n    = x.res[31];
    x.z    = (x.res == 32'd0);
    q.push_back(x);
    @(posedge clock);
    if (reset) begin
      m_pc = 32'd0;
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    end else begin
      if (wb_we && wb_addr != 4'd15) m_regs[wb_addr] = wb_data;
      if (fetch_en) m_pc = take_branch ? x.res : m_pc + 32'd1;
    end
    #1;
  endtask

  task automatic set_exec(input logic [31:0] r1, input logic [31:0] r2, input logic [2:0] op);
    rs1_data_e = r1; rs2_data_e = r2; alu_ctrl_e = op;
    fwd1_sel_e = 2'd0; fwd2_sel_e = 2'd0; src2_imm_e = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; take_branch = 1'b0; instruction_d = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    rs1_data_e = '0; rs2_data_e = '0; imm_e = '0; fwd_m = '0; fwd_wb = '0;
    alu_ctrl_e = '0; src2_imm_e = 1'b0; fwd1_sel_e = '0; fwd2_sel_e = '0;
    repeat (2) @(posedge clock);
    #1;
    m_pc = 32'd0;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    reset = 1'b0;

    // fetch sequence then stall
    fetch_en = 1'b1;
    repeat (3) step();
    fetch_en = 1'b0;
    repeat (2) step();

    // branch via pass-B of immediate, then same with stall
    take_branch = 1'b1; fetch_en = 1'b1;
    alu_ctrl_e = 3'b111; src2_imm_e = 1'b1; imm_e = 32'h40;
    step();
    fetch_en = 1'b0;
    repeat (2) step();
    take_branch = 1'b0;

    // register file: write-through, stored read, r15 read, r15 write ignored
    wb_we = 1'b1; wb_addr = 4'd3; wb_data = 32'hDEADBEEF; instruction_d = 24'h1A3400;
    step();
    wb_we = 1'b0;
    step();
    instruction_d = 24'h00F300;
    step();
    wb_we = 1'b1; wb_addr = 4'd15; wb_data = 32'h12345678; instruction_d = 24'h00FF00;
    step();
    wb_we = 1'b0;
    step();
    instruction_d = 24'h000FFF;
    step();

    // forwarding
    rs1_data_e = 32'd5; rs2_data_e = 32'd3; fwd_m = 32'd7; fwd_wb = 32'd9;
    fwd1_sel_e = 2'b10; fwd2_sel_e = 2'b01; src2_imm_e = 1'b0; alu_ctrl_e = 3'b000;
    step();
    fwd1_sel_e = 2'b11; fwd2_sel_e = 2'b11;
    step();

    // flag corners
    set_exec(32'd5, 32'd5, 3'b001);              step();
    set_exec(32'h7FFFFFFF, 32'd1, 3'b000);       step();
    set_exec(32'hFFFFFFFF, 32'd1, 3'b000);       step();
    set_exec(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010); step();
    set_exec(32'h80000000, 32'd1, 3'b001);       step();
    set_exec(32'd3, 32'd33, 3'b101);             step();

    // randomized traffic with occasional reset and branches
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 63) == 0);
      fetch_en      = ($urandom_range(0, 3) != 0);
      take_branch   = ($urandom_range(0, 7) == 0);
      instruction_d = 24'($urandom);
      wb_we         = $urandom_range(0, 1) == 1;
      wb_addr       = 4'($urandom);
      wb_data       = $urandom;
      rs1_data_e    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      rs2_data_e    = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
      imm_e         = 32'($signed(12'($urandom)));
      fwd_m         = $urandom;
      fwd_wb        = $urandom;
      alu_ctrl_e    = 3'($urandom);
      src2_imm_e    = $urandom_range(0, 1) == 1;
      fwd1_sel_e    = 2'($urandom);
      fwd2_sel_e    = 2'($urandom);
      step();
    end
    reset = 1'b0;

    @(negedge clock);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
